key_pio_in: RTL and testbench
=============================

KEY_PIO_IN -- requirements
Module: key_pio_in

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, number of key inputs (1..32).
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles (10 ms at 50 MHz) required to accept a key change; minimum 2.
REQ-003 SHALL have port CLOCK_50  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port KEY  input  WIDTH  raw asynchronous push-buttons, active-low (pressed = 0).
REQ-006 SHALL have port address  input  2  Avalon-MM slave word address.
REQ-007 SHALL have port chipselect  input  1  Avalon-MM select.
REQ-008 SHALL have port read  input  1  Avalon-MM read strobe.
REQ-009 SHALL have port write  input  1  Avalon-MM write strobe.
REQ-010 SHALL have port writedata  input  32  Avalon-MM write data.
REQ-011 SHALL have port readdata  output  32  Avalon-MM read data, registered.
REQ-012 SHALL have port irq  output  1  level interrupt to the processor, active-high.

Function
REQ-013 SHALL pass each KEY bit through a two-flop synchronizer before any other use.
REQ-014 SHALL keep one debounce counter per bit: counter clears when synchronized bit equals debounced bit; increments otherwise.
REQ-015 SHALL update a debounced bit to the synchronized value, and clear its counter, in the cycle the counter reaches DEBOUNCE_CYCLES-1 while still differing.
REQ-016 Glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave the debounced bit unchanged; counter SHALL NOT wrap.
REQ-017 SHALL detect a press as a 1->0 transition of a debounced bit and set the matching edgecapture bit the following cycle.
REQ-018 Register map: 0 data (RO, debounced KEY, zero-extended); 1 reserved (reads 0, writes ignored); 2 irqmask (RW, WIDTH bits); 3 edgecapture (RO, write-1-to-clear).
REQ-019 Writes SHALL take effect when chipselect & write in a cycle; writedata bits above WIDTH-1 ignored.
REQ-020 Reads: when chipselect & read, readdata SHALL present the addressed register on the next clock edge (read latency 1); in all other cycles readdata SHALL be 0.
REQ-021 Same-cycle press detection and write-1-to-clear on the same edgecapture bit: set SHALL win.
REQ-022 Writes to offset 0 SHALL be ignored; a simultaneous read and write SHALL return the pre-write register value.
REQ-023 irq SHALL be registered: irq = OR over bits of (edgecapture & irqmask), reflecting register state one cycle after it changes.
REQ-024 Releases (0->1) SHALL update data only, never edgecapture.

Reset
REQ-025 While RESET = 0, synchronizer flops and debounced bits SHALL be all ones (released), counters 0, irqmask 0, edgecapture 0, readdata 0, irq 0.
REQ-026 Reset asserted mid-debounce or with pending edgecapture SHALL discard all state immediately; no edge SHALL be reported on reset release while KEY is high.

Verification (bench overrides WIDTH=4, DEBOUNCE_CYCLES=4)
REQ-027 Reset then read offset 0 -> readdata = 0x0000000F one cycle after read; irq = 0.
REQ-028 KEY[0] low for 3 cycles then high -> data stays 0xF, edgecapture stays 0, irq stays 0.
REQ-029 KEY[2] held low, irqmask written 0x4 -> data reads 0xB after 2+4 cycles; edgecapture reads 0x4; irq = 1 one cycle after edgecapture set.
REQ-030 With edgecapture = 0x4, write 0x4 to offset 3 -> edgecapture reads 0, irq drops one cycle later; writing 0x1 instead leaves 0x4.
REQ-031 Press KEY[1] timed so its edgecapture set coincides with a write of 0x2 to offset 3 -> edgecapture bit 1 remains 1.
REQ-032 Assert RESET with KEY[3] low and edgecapture = 0x8, release with KEY[3] high -> all registers 0, data = 0xF, irq = 0, no new edge.

Source files
------------

// File: rtl/key_pio_in_if.sv
// Avalon-MM slave bus plus interrupt line for the key PIO.
// The processor side drives the master modport, the key block serves the slave modport.
interface key_pio_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, read, write, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, read, write, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/key_pio_in.sv
// Debounced active-low push-button input port with press capture and a level interrupt.
// Register map: 0 data, 1 reserved, 2 irqmask, 3 edgecapture (write-1-to-clear).
module key_pio_in #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic [WIDTH-1:0] KEY,
    key_pio_in_if.slave      avs
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_deb;
    logic [WIDTH-1:0] r_deb_d;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edge;
    logic [31:0]      r_readdata;
    logic             r_irq;
    logic [CW-1:0]    r_cnt [WIDTH];

    logic [WIDTH-1:0] w_upd;
    logic [WIDTH-1:0] w_press;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic             w_rd;
    logic [31:0]      w_rd_mux;
    logic             w_unused_wdata;

    assign w_wr    = avs.chipselect & avs.write;
    assign w_rd    = avs.chipselect & avs.read;
    assign w_press = r_deb_d & ~r_deb;
    assign w_clr   = (w_wr && avs.address == 2'd3) ? avs.writedata[WIDTH-1:0] : '0;
    assign w_unused_wdata = &{1'b0, avs.writedata};

    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= KEY;
            r_sync2 <= r_sync1;
        end
    end

    // Counter saturates at CNT_MAX only for the one cycle it takes to accept the change.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
        assign w_upd[gi] = (r_sync2[gi] != r_deb[gi]) && (r_cnt[gi] == CNT_MAX);

        always_ff @(posedge CLOCK_50 or negedge RESET) begin
            if (!RESET) begin
                r_cnt[gi] <= '0;
            end else if ((r_sync2[gi] == r_deb[gi]) || w_upd[gi]) begin
                r_cnt[gi] <= '0;
            end else begin
                r_cnt[gi] <= r_cnt[gi] + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            r_deb   <= '1;
            r_deb_d <= '1;
        end else begin
            r_deb   <= (r_deb & ~w_upd) | (r_sync2 & w_upd);
            r_deb_d <= r_deb;
        end
    end

    // A new press outranks a same-cycle clear of the same bit.
    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            r_mask <= '0;
            r_edge <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (w_wr && avs.address == 2'd2) begin
                r_mask <= avs.writedata[WIDTH-1:0];
            end
            r_edge <= (r_edge & ~w_clr) | w_press;
            r_irq  <= |(r_edge & r_mask);
        end
    end

    always_comb begin
        w_rd_mux = 32'd0;
        case (avs.address)
            2'd0:    w_rd_mux = 32'(r_deb);
            2'd2:    w_rd_mux = 32'(r_mask);
            2'd3:    w_rd_mux = 32'(r_edge);
            default: w_rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            r_readdata <= 32'd0;
        end else begin
            r_readdata <= w_rd ? w_rd_mux : 32'd0;
        end
    end

    assign avs.readdata = r_readdata;
    assign avs.irq      = r_irq;
endmodule

// File: tb/tb_key_pio_in.sv
// Self-checking bench for key_pio_in with WIDTH=4, DEBOUNCE_CYCLES=4.
// Expected read values are queued when a read is issued and compared when readdata returns.
module tb_key_pio_in;
    logic       clk;
    logic       rst_n;
    logic [3:0] key;
    int         errors;
    int         checks;
    logic [31:0] exp_q[$];

    key_pio_in_if bus();

    key_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst_n),
        .KEY      (key),
        .avs      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [1:0] addr, output logic [31:0] d);
        bus.address = addr; bus.chipselect = 1'b1; bus.read = 1'b1;
        @(posedge clk); #1;
        d = bus.readdata;
        bus.chipselect = 1'b0; bus.read = 1'b0;
        $display("read  addr=%0d data=0x%08h", addr, d);
    endtask

    task automatic do_write(input logic [1:0] addr, input logic [31:0] wd);
        bus.address = addr; bus.chipselect = 1'b1; bus.write = 1'b1; bus.writedata = wd;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write = 1'b0; bus.writedata = '0;
        $display("write addr=%0d data=0x%08h", addr, wd);
    endtask

    task automatic do_rw(input logic [1:0] addr, input logic [31:0] wd, output logic [31:0] d);
        bus.address = addr; bus.chipselect = 1'b1; bus.read = 1'b1; bus.write = 1'b1;
        bus.writedata = wd;
        @(posedge clk); #1;
        d = bus.readdata;
        bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
        $display("rdwr  addr=%0d wdata=0x%08h rdata=0x%08h", addr, wd, d);
    endtask

    task automatic test_reset();
        logic [31:0] got;
        logic [31:0] e;
        rst_n = 1'b0; key = 4'hF;
        bus.address = '0; bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        bus.writedata = '0;
        cyc(3);
        checks++;
        if (bus.readdata !== 32'd0 || bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs readdata=0x%08h irq=%b want 0/0", bus.readdata, bus.irq);
        end
        rst_n = 1'b1;
        cyc(1);
        exp_q.push_back(32'h0000_000F);
        do_read(2'd0, got);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin errors++; $display("FAIL reset_data got=0x%08h want=0x%08h", got, e); end
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b want=0", bus.irq); end
        cyc(1);
        checks++;
        if (bus.readdata !== 32'd0) begin
            errors++; $display("FAIL idle_readdata got=0x%08h want=0", bus.readdata);
        end
    endtask

    task automatic test_regs();
        logic [31:0] got;
        logic [31:0] e;
        do_write(2'd1, 32'hFFFF_FFFF);
        do_write(2'd0, 32'h0000_0000);
        do_write(2'd2, 32'hFFFF_FFF5);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'h0000_000F);
        exp_q.push_back(32'h0000_0005);
        do_read(2'd1, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL reserved got=0x%08h want=0x%08h", got, e); end
        do_read(2'd0, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL data_ro got=0x%08h want=0x%08h", got, e); end
        do_read(2'd2, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL mask_rw got=0x%08h want=0x%08h", got, e); end
        exp_q.push_back(32'h0000_0005);
        do_rw(2'd2, 32'h0000_0004, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL rw_prewrite got=0x%08h want=0x%08h", got, e); end
        exp_q.push_back(32'h0000_0004);
        do_read(2'd2, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL rw_postwrite got=0x%08h want=0x%08h", got, e); end
    endtask

    task automatic test_glitch();
        logic [31:0] got;
        logic [31:0] e;
        key[0] = 1'b0;
        cyc(3);
        key[0] = 1'b1;
        cyc(8);
        exp_q.push_back(32'h0000_000F);
        exp_q.push_back(32'h0000_0000);
        do_read(2'd0, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL glitch_data got=0x%08h want=0x%08h", got, e); end
        do_read(2'd3, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL glitch_edge got=0x%08h want=0x%08h", got, e); end
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL glitch_irq got=%b want=0", bus.irq); end
    endtask

    task automatic test_press_irq();
        logic [31:0] got;
        logic [31:0] e;
        key[2] = 1'b0;
        cyc(5);
        exp_q.push_back(32'h0000_000F);
        exp_q.push_back(32'h0000_000B);
        exp_q.push_back(32'h0000_0004);
        do_read(2'd0, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL press_early got=0x%08h want=0x%08h", got, e); end
        do_read(2'd0, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL press_data got=0x%08h want=0x%08h", got, e); end
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL press_irq_early got=%b want=0", bus.irq); end
        do_read(2'd3, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL press_edge got=0x%08h want=0x%08h", got, e); end
        checks++;
        if (bus.irq !== 1'b1) begin errors++; $display("FAIL press_irq got=%b want=1", bus.irq); end
        key[2] = 1'b1;
        cyc(8);
        exp_q.push_back(32'h0000_000F);
        exp_q.push_back(32'h0000_0004);
        do_read(2'd0, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL release_data got=0x%08h want=0x%08h", got, e); end
        do_read(2'd3, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL release_edge got=0x%08h want=0x%08h", got, e); end
    endtask

    task automatic test_clear();
        logic [31:0] got;
        logic [31:0] e;
        do_write(2'd3, 32'h0000_0001);
        exp_q.push_back(32'h0000_0004);
        do_read(2'd3, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL clear_other got=0x%08h want=0x%08h", got, e); end
        do_write(2'd3, 32'h0000_0004);
        checks++;
        if (bus.irq !== 1'b1) begin errors++; $display("FAIL clear_irq_lag got=%b want=1", bus.irq); end
        cyc(1);
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL clear_irq got=%b want=0", bus.irq); end
        exp_q.push_back(32'h0000_0000);
        do_read(2'd3, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL clear_edge got=0x%08h want=0x%08h", got, e); end
    endtask

    task automatic test_set_wins();
        logic [31:0] got;
        logic [31:0] e;
        key[1] = 1'b0;
        cyc(6);
        do_write(2'd3, 32'h0000_0002);
        exp_q.push_back(32'h0000_0002);
        do_read(2'd3, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL set_wins got=0x%08h want=0x%08h", got, e); end
        key[1] = 1'b1;
        cyc(8);
        do_write(2'd3, 32'h0000_0002);
        exp_q.push_back(32'h0000_0000);
        do_read(2'd3, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL set_wins_clear got=0x%08h want=0x%08h", got, e); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got;
        logic [31:0] e;
        do_write(2'd2, 32'h0000_0008);
        key[3] = 1'b0;
        key[0] = 1'b0;
        cyc(8);
        checks++;
        if (bus.irq !== 1'b1) begin errors++; $display("FAIL mid_irq_before got=%b want=1", bus.irq); end
        key[0] = 1'b1;
        cyc(1);
        key[0] = 1'b0;
        cyc(3);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL mid_irq_async got=%b want=0", bus.irq); end
        key = 4'hF;
        cyc(3);
        rst_n = 1'b1;
        cyc(10);
        exp_q.push_back(32'h0000_000F);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0000);
        do_read(2'd0, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL mid_data got=0x%08h want=0x%08h", got, e); end
        do_read(2'd2, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL mid_mask got=0x%08h want=0x%08h", got, e); end
        do_read(2'd3, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL mid_edge got=0x%08h want=0x%08h", got, e); end
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL mid_irq_after got=%b want=0", bus.irq); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_regs();
        test_glitch();
        test_press_irq();
        test_clear();
        test_set_wins();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
